// File: rtl/decim_serializer.sv
`default_nettype none
// ============================================================================
// Module      : decim_serializer
// Description : Double-buffered capture of 16-word decimator blocks, streamed
//               out one saturated Q.8 sample per handshake.
// Revision    : 1.0
// ============================================================================
module decim_serializer #(
    parameter int IN_WIDTH    = 67,
    parameter int OUT_WIDTH   = 32,
    parameter int NUM_SAMPLES = 16,
    parameter int FRAC_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  block_in [0:NUM_SAMPLES-1],
    input  logic                 block_valid,
    output logic                 block_ready,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 sample_last,
    output logic                 sat_flag,
    output logic [7:0]           drop_count
);

    localparam int                  c_IDX_W    = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(NUM_SAMPLES - 1);
    // Input and output share the same Q format, so the alignment shift is zero.
    localparam int                  c_SHIFT    = FRAC_BITS - FRAC_BITS;
    localparam logic [OUT_WIDTH-1:0] c_POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_NEG_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [IN_WIDTH-1:0] r_bank [0:1][0:NUM_SAMPLES-1];

    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_drop;

    logic                           w_block_ready;
    logic                           w_sample_valid;
    logic                           w_accept;
    logic                           w_drop;
    logic                           w_pop;
    logic                           w_pop_last;
    logic signed [IN_WIDTH-1:0]     w_word;
    logic signed [IN_WIDTH-1:0]     w_scaled;
    logic [IN_WIDTH-OUT_WIDTH:0]    w_hi;
    logic                           w_ovf;

    assign w_block_ready  = (r_count != 2'd2);
    assign w_sample_valid = (r_count != 2'd0);
    assign w_accept       = block_valid && w_block_ready;
    assign w_drop         = block_valid && !w_block_ready;
    assign w_pop          = w_sample_valid && sample_ready;
    assign w_pop_last     = w_pop && (r_idx == c_IDX_LAST);

    // Bank storage is deliberately left out of reset; occupancy lives in r_count.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                r_bank[r_wr_ptr][i] <= block_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_idx    <= '0;
            r_drop   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if (w_pop) begin
                if (w_pop_last) begin
                    r_idx    <= '0;
                    r_rd_ptr <= ~r_rd_ptr;
                end else begin
                    r_idx <= r_idx + c_IDX_W'(1);
                end
            end
            case ({w_accept, w_pop_last})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Out of range when the bits above the output sign bit are not a pure sign extension.
    assign w_word   = r_bank[r_rd_ptr][r_idx];
    assign w_scaled = w_word >>> c_SHIFT;
    assign w_hi     = w_scaled[IN_WIDTH-1:OUT_WIDTH-1];
    assign w_ovf    = !((&w_hi) || !(|w_hi));

    always_comb begin
        sample_out = '0;
        sat_flag   = 1'b0;
        if (w_sample_valid) begin
            if (w_ovf) begin
                sat_flag   = 1'b1;
                sample_out = w_scaled[IN_WIDTH-1] ? c_NEG_MIN : c_POS_MAX;
            end else begin
                sample_out = w_scaled[OUT_WIDTH-1:0];
            end
        end
    end

    assign block_ready  = w_block_ready;
    assign sample_valid = w_sample_valid;
    assign sample_last  = w_sample_valid && (r_idx == c_IDX_LAST);
    assign drop_count   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_decim_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decim_serializer
// Description : Directed self-checking bench for decim_serializer.
// Revision    : 1.0
// ============================================================================
module tb_decim_serializer;

    logic        clk;
    logic        rst;
    logic [66:0] blk [0:15];
    logic        block_valid;
    logic        block_ready;
    logic [31:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic        sample_last;
    logic        sat_flag;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    decim_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .block_in     (blk),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_last  (sample_last),
        .sat_flag     (sat_flag),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [66:0] base, input logic [66:0] step);
        for (int i = 0; i < 16; i++) blk[i] = base + step * 67'(i);
    endtask

    task automatic pulse();
        block_valid = 1'b1;
        tick();
        block_valid = 1'b0;
    endtask

    logic [66:0] t;
    int          k;
    int          cyc;

    initial begin
        rst = 1'b1; block_valid = 1'b0; sample_ready = 1'b0;
        load(67'd0, 67'd0);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_out",   64'(sample_out),   64'd0);
        check("rst_last",  64'(sample_last),  64'd0);
        check("rst_sat",   64'(sat_flag),     64'd0);
        check("rst_ready", 64'(block_ready),  64'd1);
        check("rst_drop",  64'(drop_count),   64'd0);

        // Single block 0.5 .. 8.0 in Q.8
        load(67'h80, 67'h80);
        sample_ready = 1'b1;
        pulse();
        for (int i = 0; i < 16; i++) begin
            check("single_valid", 64'(sample_valid), 64'd1);
            check("single_out",   64'(sample_out),   64'h80 * 64'(i + 1));
            check("single_last",  64'(sample_last),  (i == 15) ? 64'd1 : 64'd0);
            tick();
        end
        check("single_done", 64'(sample_valid), 64'd0);

        // Backpressure with ready pattern 1,0,0
        sample_ready = 1'b0;
        load(67'h100, 67'h100);
        pulse();
        k = 0; cyc = 0;
        while (k < 16 && cyc < 100) begin
            sample_ready = ((cyc % 3) == 0);
            check("bp_valid", 64'(sample_valid), 64'd1);
            check("bp_out",   64'(sample_out),   64'h100 * 64'(k + 1));
            check("bp_last",  64'(sample_last),  (k == 15) ? 64'd1 : 64'd0);
            tick();
            if (sample_ready) k++;
            cyc++;
        end
        check("bp_count", 64'(k), 64'd16);
        check("bp_done",  64'(sample_valid), 64'd0);

        // Overflow: three blocks two cycles apart while stalled
        sample_ready = 1'b0;
        load(67'h1000, 67'd1);
        pulse();
        tick();
        check("ovf_ready1", 64'(block_ready), 64'd1);
        load(67'h2000, 67'd1);
        pulse();
        check("ovf_ready2", 64'(block_ready), 64'd0);
        tick();
        load(67'h3000, 67'd1);
        pulse();
        check("ovf_drop",   64'(drop_count),  64'd1);
        check("ovf_ready3", 64'(block_ready), 64'd0);
        check("ovf_hold",   64'(sample_out),  64'h1000);
        sample_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("ovf_out",  64'(sample_out),
                  (i < 16) ? (64'h1000 + 64'(i)) : (64'h2000 + 64'(i - 16)));
            check("ovf_last", 64'(sample_last), (i == 15 || i == 31) ? 64'd1 : 64'd0);
            tick();
        end
        check("ovf_done",  64'(sample_valid), 64'd0);
        check("ovf_free",  64'(block_ready),  64'd1);

        // Saturation corners
        load(67'd0, 67'd0);
        blk[0] = 67'd1 << 40;
        t = 67'd1 << 40; blk[1] = -t;
        blk[2] = 67'h7FFF_FFFF;
        t = 67'd1 << 31; blk[3] = -t;
        pulse();
        check("sat0_out", 64'(sample_out), 64'h7FFF_FFFF); check("sat0_flag", 64'(sat_flag), 64'd1);
        tick();
        check("sat1_out", 64'(sample_out), 64'h8000_0000); check("sat1_flag", 64'(sat_flag), 64'd1);
        tick();
        check("sat2_out", 64'(sample_out), 64'h7FFF_FFFF); check("sat2_flag", 64'(sat_flag), 64'd0);
        tick();
        check("sat3_out", 64'(sample_out), 64'h8000_0000); check("sat3_flag", 64'(sat_flag), 64'd0);
        for (int i = 0; i < 13; i++) tick();
        check("sat_done", 64'(sample_valid), 64'd0);

        // Accept coinciding with last pop, one bank occupied
        load(67'h500, 67'd1);
        pulse();
        for (int i = 0; i < 15; i++) tick();
        check("coin1_last", 64'(sample_last), 64'd1);
        load(67'h600, 67'd1);
        pulse();
        check("coin1_valid", 64'(sample_valid), 64'd1);
        check("coin1_out",   64'(sample_out),   64'h600);
        check("coin1_ready", 64'(block_ready),  64'd1);
        for (int i = 0; i < 16; i++) tick();
        check("coin1_done",  64'(sample_valid), 64'd0);

        // Same coincidence with both banks full: block dropped
        sample_ready = 1'b0;
        load(67'h700, 67'd1);
        pulse();
        load(67'h800, 67'd1);
        pulse();
        sample_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("coin2_last",  64'(sample_last), 64'd1);
        check("coin2_full",  64'(block_ready), 64'd0);
        load(67'h900, 67'd1);
        pulse();
        check("coin2_drop",  64'(drop_count),  64'd2);
        check("coin2_out",   64'(sample_out),  64'h800);
        check("coin2_ready", 64'(block_ready), 64'd1);
        for (int i = 0; i < 16; i++) tick();
        check("coin2_done",  64'(sample_valid), 64'd0);

        // Reset mid-stream at word 7 with a second block queued
        sample_ready = 1'b0;
        load(67'hA00, 67'd1);
        pulse();
        load(67'hB00, 67'd1);
        pulse();
        sample_ready = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mrst_word7", 64'(sample_out), 64'hA07);
        load(67'hC00, 67'd1);
        rst = 1'b1; block_valid = 1'b1;
        tick();
        rst = 1'b0; block_valid = 1'b0;
        check("mrst_valid", 64'(sample_valid), 64'd0);
        check("mrst_ready", 64'(block_ready),  64'd1);
        check("mrst_drop",  64'(drop_count),   64'd0);
        load(67'hD00, 67'd1);
        pulse();
        for (int i = 0; i < 16; i++) begin
            check("mrst_out", 64'(sample_out), 64'hD00 + 64'(i));
            tick();
        end
        check("mrst_done", 64'(sample_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
